// File: rtl/risc_ctrl_unit.sv
// Control FSM for the 8-bit RISC machine: sequences fetch/decode/execute and
// drives datapath load enables, bus selects and the memory write strobe.
module risc_ctrl_unit #(
  parameter int unsigned STATE_W = 4,
  parameter logic [2:0]  SEL1_PC = 3'd4
) (
  input  logic               ctrl_clk,
  input  logic               ctrl_rst,
  input  logic [7:0]         ctrl_instr,
  input  logic               ctrl_zflag,
  output logic [3:0]         ctrl_ld_r,
  output logic               ctrl_ld_pc,
  output logic               ctrl_inc_pc,
  output logic [2:0]         ctrl_sel_bus1,
  output logic [1:0]         ctrl_sel_bus2,
  output logic               ctrl_ld_ir,
  output logic               ctrl_ld_addr,
  output logic               ctrl_ld_y,
  output logic               ctrl_ld_z,
  output logic               ctrl_mem_wr,
  output logic               ctrl_halted,
  output logic [STATE_W-1:0] ctrl_state
);

  localparam logic [STATE_W-1:0] S_IDLE = STATE_W'(0);
  localparam logic [STATE_W-1:0] S_FET1 = STATE_W'(1);
  localparam logic [STATE_W-1:0] S_FET2 = STATE_W'(2);
  localparam logic [STATE_W-1:0] S_DEC  = STATE_W'(3);
  localparam logic [STATE_W-1:0] S_EX1  = STATE_W'(4);
  localparam logic [STATE_W-1:0] S_RD1  = STATE_W'(5);
  localparam logic [STATE_W-1:0] S_RD2  = STATE_W'(6);
  localparam logic [STATE_W-1:0] S_WR1  = STATE_W'(7);
  localparam logic [STATE_W-1:0] S_WR2  = STATE_W'(8);
  localparam logic [STATE_W-1:0] S_BR1  = STATE_W'(9);
  localparam logic [STATE_W-1:0] S_BR2  = STATE_W'(10);
  localparam logic [STATE_W-1:0] S_HALT = STATE_W'(11);

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_NOT = 4'd4;
  localparam logic [3:0] OP_RD  = 4'd5;
  localparam logic [3:0] OP_WR  = 4'd6;
  localparam logic [3:0] OP_BR  = 4'd7;
  localparam logic [3:0] OP_BRZ = 4'd8;

  localparam logic [1:0] SEL2_ALU  = 2'd0;
  localparam logic [1:0] SEL2_BUS1 = 2'd1;
  localparam logic [1:0] SEL2_MEM  = 2'd2;

  logic [STATE_W-1:0] state_q, state_d;
  logic [3:0]         opcode;
  logic [2:0]         src_sel;
  logic [2:0]         dst_sel;
  logic [3:0]         dst_onehot;

  assign opcode     = ctrl_instr[7:4];
  assign src_sel    = {1'b0, ctrl_instr[3:2]};
  assign dst_sel    = {1'b0, ctrl_instr[1:0]};
  assign dst_onehot = 4'b0001 << ctrl_instr[1:0];

  // State register
  always_ff @(posedge ctrl_clk) begin
    if (ctrl_rst) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; unused encodings recover to IDLE
  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE: state_d = S_FET1;
      S_FET1: state_d = S_FET2;
      S_FET2: state_d = S_DEC;
      S_DEC: begin
        case (opcode)
          OP_NOP, OP_NOT:         state_d = S_FET1;
          OP_ADD, OP_SUB, OP_AND: state_d = S_EX1;
          OP_RD:                  state_d = S_RD1;
          OP_WR:                  state_d = S_WR1;
          OP_BR:                  state_d = S_BR1;
          OP_BRZ:                 state_d = ctrl_zflag ? S_BR1 : S_FET1;
          default:                state_d = S_HALT;
        endcase
      end
      S_EX1:  state_d = S_FET1;
      S_RD1:  state_d = S_RD2;
      S_RD2:  state_d = S_FET1;
      S_WR1:  state_d = S_WR2;
      S_WR2:  state_d = S_FET1;
      S_BR1:  state_d = S_BR2;
      S_BR2:  state_d = S_FET1;
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode; reset forces every control low in the same cycle
  always_comb begin
    ctrl_ld_r     = 4'b0000;
    ctrl_ld_pc    = 1'b0;
    ctrl_inc_pc   = 1'b0;
    ctrl_sel_bus1 = 3'd0;
    ctrl_sel_bus2 = SEL2_ALU;
    ctrl_ld_ir    = 1'b0;
    ctrl_ld_addr  = 1'b0;
    ctrl_ld_y     = 1'b0;
    ctrl_ld_z     = 1'b0;
    ctrl_mem_wr   = 1'b0;
    ctrl_halted   = 1'b0;
    if (!ctrl_rst) begin
      case (state_q)
        S_FET1: begin
          ctrl_sel_bus1 = SEL1_PC;
          ctrl_sel_bus2 = SEL2_BUS1;
          ctrl_ld_addr  = 1'b1;
        end
        S_FET2: begin
          ctrl_sel_bus2 = SEL2_MEM;
          ctrl_ld_ir    = 1'b1;
          ctrl_inc_pc   = 1'b1;
        end
        S_DEC: begin
          case (opcode)
            OP_ADD, OP_SUB, OP_AND: begin
              ctrl_sel_bus1 = src_sel;
              ctrl_sel_bus2 = SEL2_BUS1;
              ctrl_ld_y     = 1'b1;
            end
            OP_NOT: begin
              ctrl_sel_bus1 = src_sel;
              ctrl_sel_bus2 = SEL2_ALU;
              ctrl_ld_z     = 1'b1;
              ctrl_ld_r     = dst_onehot;
            end
            OP_RD, OP_WR, OP_BR: begin
              ctrl_sel_bus1 = SEL1_PC;
              ctrl_sel_bus2 = SEL2_BUS1;
              ctrl_ld_addr  = 1'b1;
            end
            OP_BRZ: begin
              if (ctrl_zflag) begin
                ctrl_sel_bus1 = SEL1_PC;
                ctrl_sel_bus2 = SEL2_BUS1;
                ctrl_ld_addr  = 1'b1;
              end else begin
                ctrl_inc_pc   = 1'b1;
              end
            end
            default: ;
          endcase
        end
        S_EX1: begin
          ctrl_sel_bus1 = dst_sel;
          ctrl_sel_bus2 = SEL2_ALU;
          ctrl_ld_z     = 1'b1;
          ctrl_ld_r     = dst_onehot;
        end
        S_RD1, S_WR1: begin
          ctrl_sel_bus2 = SEL2_MEM;
          ctrl_ld_addr  = 1'b1;
          ctrl_inc_pc   = 1'b1;
        end
        S_RD2: begin
          ctrl_sel_bus2 = SEL2_MEM;
          ctrl_ld_r     = dst_onehot;
        end
        S_WR2: begin
          ctrl_sel_bus1 = src_sel;
          ctrl_mem_wr   = 1'b1;
        end
        S_BR1: begin
          ctrl_sel_bus2 = SEL2_MEM;
          ctrl_ld_addr  = 1'b1;
        end
        S_BR2: begin
          ctrl_sel_bus2 = SEL2_MEM;
          ctrl_ld_pc    = 1'b1;
        end
        S_HALT: ctrl_halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign ctrl_state = ctrl_rst ? '0 : state_q;

endmodule

// File: tb/tb_risc_ctrl_unit.sv
// Scoreboard bench for risc_ctrl_unit: a per-instruction cycle-sequence model
// queues expected control vectors; a negedge monitor pops and compares.
module tb_risc_ctrl_unit;

  typedef struct packed {
    logic [3:0] ld_r;
    logic       ld_pc;
    logic       inc_pc;
    logic [2:0] sel1;
    logic [1:0] sel2;
    logic       ld_ir;
    logic       ld_addr;
    logic       ld_y;
    logic       ld_z;
    logic       mem_wr;
    logic       halted;
    logic [3:0] state;
  } outv_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] instr = 8'h00;
  logic       zflag = 1'b0;

  logic [3:0] ld_r;
  logic       ld_pc, inc_pc, ld_ir, ld_addr, ld_y, ld_z, mem_wr, halted;
  logic [2:0] sel1;
  logic [1:0] sel2;
  logic [3:0] state;

  int passed = 0;
  int total  = 0;
  int cycle_n = 0;
  outv_t exp_q[$];

  risc_ctrl_unit dut (
    .ctrl_clk(clk), .ctrl_rst(rst), .ctrl_instr(instr), .ctrl_zflag(zflag),
    .ctrl_ld_r(ld_r), .ctrl_ld_pc(ld_pc), .ctrl_inc_pc(inc_pc),
    .ctrl_sel_bus1(sel1), .ctrl_sel_bus2(sel2), .ctrl_ld_ir(ld_ir),
    .ctrl_ld_addr(ld_addr), .ctrl_ld_y(ld_y), .ctrl_ld_z(ld_z),
    .ctrl_mem_wr(mem_wr), .ctrl_halted(halted), .ctrl_state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  function automatic string sname(input logic [3:0] s);
    case (s)
      4'd0: return "IDLE"; 4'd1: return "FET1"; 4'd2: return "FET2";
      4'd3: return "DEC";  4'd4: return "EX1";  4'd5: return "RD1";
      4'd6: return "RD2";  4'd7: return "WR1";  4'd8: return "WR2";
      4'd9: return "BR1";  4'd10: return "BR2"; 4'd11: return "HALT";
      default: return "BAD";
    endcase
  endfunction

  function automatic outv_t mk(input int st);
    outv_t v;
    v = '0;
    v.state = 4'(st);
    return v;
  endfunction

  // Monitor: compare against scoreboard and check the output invariants
  always @(negedge clk) begin
    outv_t act, e;
    act = '{ld_r, ld_pc, inc_pc, sel1, sel2, ld_ir, ld_addr, ld_y, ld_z, mem_wr, halted, state};
    cycle_n++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (act === e) passed++;
      else $display("FAIL %s cycle %0d: actual=%b required=%b", sname(e.state), cycle_n, act, e);
    end
    total++;
    if (!$isunknown(ld_r) && $countones(ld_r) <= 1 && !(ld_pc && inc_pc) &&
        (!mem_wr || state == 4'd8)) passed++;
    else $display("FAIL invariant cycle %0d: actual ld_r=%b ld_pc=%b inc_pc=%b mem_wr=%b state=%0d required one-hot/exclusive/WR2-only",
                  cycle_n, ld_r, ld_pc, inc_pc, mem_wr, state);
  end

  task automatic cyc(input logic r, input logic [7:0] ins, input logic z, input outv_t e);
    @(posedge clk);
    #1;
    rst = r; instr = ins; zflag = z;
    exp_q.push_back(e);
  endtask

  // One reset cycle (all outputs low) followed by the IDLE cycle
  task automatic do_reset();
    cyc(1'b1, 8'($urandom), 1'($urandom), mk(0));
    cyc(1'b0, 8'($urandom), 1'($urandom), mk(0));
  endtask

  // Build the expected cycle sequence for one instruction and play it out.
  // rst_at >= 0 asserts reset in that cycle of the instruction.
  task automatic run_instr(input logic [7:0] ins, input logic z, input int rst_at, input int halt_n);
    outv_t seq[$];
    outv_t v;
    logic [3:0] op;
    logic [2:0] src, dst;
    logic [3:0] oh;
    bit illegal;
    op = ins[7:4]; src = {1'b0, ins[3:2]}; dst = {1'b0, ins[1:0]};
    oh = 4'b0001 << ins[1:0];
    illegal = 0;
    v = mk(1); v.sel1 = 3'd4; v.sel2 = 2'd1; v.ld_addr = 1; seq.push_back(v);
    v = mk(2); v.sel2 = 2'd2; v.ld_ir = 1; v.inc_pc = 1; seq.push_back(v);
    v = mk(3);
    if (op == 4'd0) seq.push_back(v);
    else if (op <= 4'd3) begin
      v.sel1 = src; v.sel2 = 2'd1; v.ld_y = 1; seq.push_back(v);
      v = mk(4); v.sel1 = dst; v.sel2 = 2'd0; v.ld_z = 1; v.ld_r = oh; seq.push_back(v);
    end else if (op == 4'd4) begin
      v.sel1 = src; v.sel2 = 2'd0; v.ld_z = 1; v.ld_r = oh; seq.push_back(v);
    end else if (op == 4'd8 && !z) begin
      v.inc_pc = 1; seq.push_back(v);
    end else if (op <= 4'd8) begin
      v.sel1 = 3'd4; v.sel2 = 2'd1; v.ld_addr = 1; seq.push_back(v);
      if (op == 4'd5) begin
        v = mk(5); v.sel2 = 2'd2; v.ld_addr = 1; v.inc_pc = 1; seq.push_back(v);
        v = mk(6); v.sel2 = 2'd2; v.ld_r = oh; seq.push_back(v);
      end else if (op == 4'd6) begin
        v = mk(7); v.sel2 = 2'd2; v.ld_addr = 1; v.inc_pc = 1; seq.push_back(v);
        v = mk(8); v.sel1 = src; v.mem_wr = 1; seq.push_back(v);
      end else begin
        v = mk(9); v.sel2 = 2'd2; v.ld_addr = 1; seq.push_back(v);
        v = mk(10); v.sel2 = 2'd2; v.ld_pc = 1; seq.push_back(v);
      end
    end else begin
      illegal = 1;
      seq.push_back(v);
      for (int i = 0; i < halt_n; i++) begin
        v = mk(11); v.halted = 1; seq.push_back(v);
      end
    end
    for (int i = 0; i < seq.size(); i++) begin
      if (i == rst_at) begin
        do_reset();
        return;
      end
      if (seq[i].state == 4'd11)
        cyc(1'b0, 8'($urandom), 1'($urandom), seq[i]);
      else if (i == 2)
        cyc(1'b0, ins, z, seq[i]);
      else
        cyc(1'b0, ins, 1'($urandom), seq[i]);
    end
    if (illegal) do_reset();
  endtask

  initial begin
    logic [7:0] ins;
    logic [3:0] op;
    int ra;
    cyc(1'b1, 8'h00, 1'b0, mk(0));
    cyc(1'b1, 8'h00, 1'b0, mk(0));
    cyc(1'b0, 8'h00, 1'b0, mk(0));
    run_instr(8'h1B, 1'b0, -1, 0);
    run_instr(8'h80, 1'b1, -1, 0);
    run_instr(8'h80, 1'b0, -1, 0);
    run_instr(8'h5D, 1'b0, -1, 0);
    run_instr(8'h68, 1'b1, -1, 0);
    run_instr(8'h42, 1'b0, -1, 0);
    run_instr(8'h00, 1'b1, -1, 0);
    run_instr(8'h7F, 1'b0, -1, 0);
    run_instr(8'hF0, 1'b0, -1, 20);
    run_instr(8'h27, 1'b0, 3, 0);
    run_instr(8'h36, 1'b1, -1, 0);
    for (int n = 0; n < 300; n++) begin
      op = 4'($urandom_range(0, 9));
      if (op == 4'd9) op = 4'($urandom_range(9, 15));
      ins = {op, 4'($urandom)};
      ra = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 4) : -1;
      run_instr(ins, 1'($urandom), ra, $urandom_range(1, 6));
    end
    for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    total++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL drain: actual=%0d pending required=0", exp_q.size());
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/risc_ctrl_unit.md
Name: risc_ctrl_unit

Overview:
- Moore/Mealy control FSM for the 8-bit RISC stored-program machine.
- Sequences fetch, decode and execute.
- Drives register, PC, IR, address-register, Y-register and zero-flag load enables, plus both bus mux selects and the memory write strobe.
- Consumes the IR contents and the registered zero flag for conditional branches.

Parameters:
- STATE_W, 4, width of the exported state vector (12 states used).
- SEL1_PC, 3'd4, ctrl_sel_bus1 code that selects the PC onto Bus1 (codes 0-3 select R0-R3).

Ports:
- ctrl_clk  in  1  system clock, all state updates on rising edge
- ctrl_rst  in  1  synchronous, active-high reset
- ctrl_instr  in  8  IR contents: [7:4] opcode, [3:2] src reg, [1:0] dest reg
- ctrl_zflag  in  1  registered ALU zero flag
- ctrl_ld_r  out  4  one-hot load enable for R0..R3
- ctrl_ld_pc  out  1  load PC from Bus2
- ctrl_inc_pc  out  1  increment PC
- ctrl_sel_bus1  out  3  Bus1 source: 0-3 = R0-R3, 4 = PC
- ctrl_sel_bus2  out  2  Bus2 source: 0 = ALU, 1 = Bus1, 2 = memory
- ctrl_ld_ir  out  1  load IR from Bus2
- ctrl_ld_addr  out  1  load address register from Bus2
- ctrl_ld_y  out  1  load ALU Y register from Bus2
- ctrl_ld_z  out  1  load zero-flag register
- ctrl_mem_wr  out  1  memory write strobe
- ctrl_halted  out  1  high in HALT state
- ctrl_state  out  STATE_W  current state, for debug and bench

Behaviour:
- States: IDLE=0, FET1, FET2, DEC, EX1, RD1, RD2, WR1, WR2, BR1, BR2, HALT=11.
- Opcodes: NOP=0, ADD=1, SUB=2, AND=3, NOT=4, RD=5, WR=6, BR=7, BRZ=8. Opcodes 9-15 are illegal.
- Output defaults: every output is 0 unless listed below. Outputs are combinational from state, ctrl_instr and ctrl_zflag.
- Reset:
  - While ctrl_rst=1, all outputs are forced to 0.
  - On the next edge, state becomes IDLE, from any state, including mid-instruction and HALT.
- IDLE: no outputs. Goes to FET1 unconditionally.
- FET1: sel_bus1=PC, sel_bus2=1, ld_addr. Goes to FET2.
- FET2: sel_bus2=2, ld_ir, inc_pc. Goes to DEC.
- DEC, by opcode:
  - NOP: no outputs; goes to FET1.
  - ADD/SUB/AND: sel_bus1=src, sel_bus2=1, ld_y; goes to EX1.
  - NOT: sel_bus1=src, sel_bus2=0, ld_z, ld_r[dest]; goes to FET1.
  - RD, WR, BR: sel_bus1=PC, sel_bus2=1, ld_addr. Next state is RD1, WR1 or BR1 respectively.
  - BRZ with ctrl_zflag=1: same outputs as BR; goes to BR1.
  - BRZ with ctrl_zflag=0: inc_pc only (skips the address byte); goes to FET1.
  - Illegal opcode: no outputs; goes to HALT.
- EX1: sel_bus1=dest, sel_bus2=0, ld_z, ld_r[dest]. Goes to FET1. The ALU takes its opcode directly from the IR.
- RD1: sel_bus2=2, ld_addr, inc_pc. Goes to RD2.
- RD2: sel_bus2=2, ld_r[dest]. Goes to FET1.
- WR1: sel_bus2=2, ld_addr, inc_pc. Goes to WR2.
- WR2: sel_bus1=src, mem_wr. Goes to FET1.
- BR1: sel_bus2=2, ld_addr. Goes to BR2.
- BR2: sel_bus2=2, ld_pc. Goes to FET1.
- HALT: ctrl_halted=1, all other outputs 0. Remains in HALT until reset.
- Instruction latency in cycles:
  - NOP and NOT: 3.
  - ADD/SUB/AND: 4.
  - RD, WR, BR and taken BRZ: 5.
  - Untaken BRZ: 3.
- Output invariants:
  - ctrl_ld_r is never multi-hot.
  - ctrl_ld_pc and ctrl_inc_pc are never both 1.
  - ctrl_mem_wr is high only in WR2.
- ctrl_zflag is sampled only in DEC. A flag change in any other state has no effect.
- Unused encodings 12-15 on the state register go to IDLE on the next edge, with all outputs 0.

Test Plan:
- Reset, then release → cycle 0 state=IDLE with all outputs 0; cycle 1 FET1 with sel_bus1=4, sel_bus2=1, ld_addr=1; cycle 2 FET2 with ld_ir=1, inc_pc=1.
- instr=8'h1B (ADD R2→R3) at DEC → DEC: sel_bus1=2, ld_y=1. EX1: sel_bus1=3, sel_bus2=0, ld_z=1, ld_r=4'b1000. Then FET1.
- instr=8'h80 (BRZ), zflag=1 → DEC, BR1, BR2 sequence, with ld_pc=1 in BR2. Repeat with zflag=0 → DEC shows inc_pc=1 only, then FET1.
- instr=8'h5D (RD→R1) and instr=8'h68 (WR from R2) → RD2: ld_r=4'b0010, sel_bus2=2. WR2: sel_bus1=2, mem_wr=1 for exactly 1 cycle.
- instr=8'hF0 (illegal) → HALT, ctrl_halted=1, held for 20 cycles with zflag and instr toggling.
- Assert ctrl_rst in EX1 and in HALT → outputs 0 in the reset cycle, IDLE on the next edge, FET1 one cycle after release.
